// File: rtl/video_int_gen_if.sv
// Bundle between the video timing / port register side and the raster interrupt generator.
// The master drives strobes, compare values, mask and acknowledge; the slave returns INT state and position.
interface video_int_gen_if;
    logic       line_start;
    logic       frame_start;
    logic       htick;
    logic [8:0] vint_beg;
    logic [7:0] hint_beg;
    logic [2:0] intmask;
    logic       dma_end;
    logic       int_ack;
    logic       int_start;
    logic       int_n;
    logic [7:0] int_vec;
    logic [8:0] vcnt;
    logic [7:0] hcnt;

    modport master (
        output line_start, frame_start, htick, vint_beg, hint_beg, intmask, dma_end, int_ack,
        input  int_start, int_n, int_vec, vcnt, hcnt
    );

    modport slave (
        input  line_start, frame_start, htick, vint_beg, hint_beg, intmask, dma_end, int_ack,
        output int_start, int_n, int_vec, vcnt, hcnt
    );
endinterface

// File: rtl/video_int_gen.sv
// Raster interrupt generator: tracks raster position, raises frame/line/DMA interrupts,
// holds them for an INT_LEN window and serves the IM2 vector on acknowledge.
module video_int_gen #(
    parameter int INT_LEN = 32
) (
    input  logic           clk,
    input  logic           res,
    video_int_gen_if.slave bus
);
    localparam logic [7:0] LEN = 8'(INT_LEN);

    logic [8:0] vcnt;
    logic [7:0] hcnt;
    logic [2:0] pend, pend_nxt, set, clr, kept;
    logic [7:0] wcnt, wcnt_nxt;
    logic       frame_ev;
    logic       int_start;

    // Compare against pre-update counters and the compare values present this cycle
    assign frame_ev = bus.htick && !bus.line_start &&
                      (vcnt == bus.vint_beg) && (hcnt == bus.hint_beg);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vcnt <= '0;
            hcnt <= '0;
        end else if (bus.frame_start) begin
            vcnt <= '0;
            hcnt <= '0;
        end else if (bus.line_start) begin
            if (vcnt != 9'd511) vcnt <= vcnt + 9'd1;
            hcnt <= '0;
        end else if (bus.htick) begin
            if (hcnt != 8'd255) hcnt <= hcnt + 8'd1;
        end
    end

    always_comb begin
        set = {bus.dma_end, bus.line_start, frame_ev} & bus.intmask;
        clr = '0;
        if (bus.int_ack) begin
            if (pend[0])      clr = 3'b001;
            else if (pend[1]) clr = 3'b010;
            else if (pend[2]) clr = 3'b100;
        end
        // A fresh set overrides an ack-clear of the same bit
        kept     = pend & ~clr & bus.intmask;
        pend_nxt = kept | set;
        wcnt_nxt = wcnt;
        if (|set) begin
            wcnt_nxt = LEN;
        end else if (bus.int_ack && |kept) begin
            wcnt_nxt = LEN;
        end else if (|pend && wcnt != 8'd0) begin
            wcnt_nxt = wcnt - 8'd1;
            // Untaken requests are dropped when the window runs out
            if (wcnt == 8'd1) pend_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pend      <= '0;
            wcnt      <= '0;
            int_start <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            wcnt      <= wcnt_nxt;
            int_start <= frame_ev;
        end
    end

    always_comb begin
        if (pend[0])      bus.int_vec = 8'hFF;
        else if (pend[1]) bus.int_vec = 8'hFD;
        else if (pend[2]) bus.int_vec = 8'hFB;
        else              bus.int_vec = 8'hFF;
    end

    assign bus.int_n     = ~|pend;
    assign bus.int_start = int_start;
    assign bus.vcnt      = vcnt;
    assign bus.hcnt      = hcnt;
endmodule
